fft_stream_frame_adapter: RTL and testbench
===========================================

// Module: fft_stream_frame_adapter
// PURPOSE
//  - Streaming front/back end for the parallel N-point FFT core (fft_32point and its parametrised successors).
//  - Collects N real samples from a valid/ready stream into a frame and holds them stable on the core's flat input bus.
//  - Waits the core's fixed pipeline latency, then captures all N complex outputs.
//  - Drains the captured outputs one bin per beat on a valid/ready stream with index and last tags.
// PARAMETERS
//  N_POINTS      32  FFT size; power of two, 4..256
//  DATA_W        32  width of each real/imag word
//  CORE_LATENCY  30  clock edges from frame presented to core outputs valid; >=1
// PORTS
//  clk          in   1                  clock; all logic on rising edge
//  rst          in   1                  asynchronous reset, active-low
//  s_valid      in   1                  input sample valid
//  s_ready      out  1                  adapter accepts sample
//  s_data       in   DATA_W             real input sample
//  s_last       in   1                  marks last sample of frame
//  core_in      out  N_POINTS*DATA_W    frame to core; sample k at [k*DATA_W +: DATA_W]
//  core_out_r   in   N_POINTS*DATA_W    core real outputs, same packing
//  core_out_i   in   N_POINTS*DATA_W    core imaginary outputs, same packing
//  m_valid      out  1                  output bin valid
//  m_ready      in   1                  downstream accepts bin
//  m_data_r     out  DATA_W             bin real part
//  m_data_i     out  DATA_W             bin imaginary part
//  m_index      out  log2(N_POINTS)     bin index of current beat
//  m_last       out  1                  high on final bin of frame
//  busy         out  1                  high in WAIT or DRAIN
//  len_err      out  1                  one-cycle pulse on frame length mismatch
// BEHAVIOUR
//  - Reset (rst=0): state FILL; all outputs 0, including s_ready, core_in, m_*, busy, len_err; counters 0.
//  - Deassertion: s_ready rises after the first rising edge with rst=1.
//  - Handshake: beat transfers on an edge with valid&ready both high.
//  - Source may hold valid indefinitely; m_data_*/m_index/m_last are stable while m_valid&!m_ready.
//  - FSM FILL: s_ready=1. Each accepted sample is written to core_in slot wr_cnt, then wr_cnt++.
//    - Early last (s_last=1 with wr_cnt<N-1): sample dropped, wr_cnt->0, len_err pulses, remain in FILL.
//    - Frame complete (sample accepted with wr_cnt==N-1):
//      - go to WAIT; s_ready drops on the same edge; wait_cnt loads CORE_LATENCY-1.
//      - if s_last=0 on that beat, len_err pulses but the frame is still processed.
//  - FSM WAIT: core_in held constant; wait_cnt decrements each edge.
//    - At wait_cnt==0: on that edge, register all core_out_r/core_out_i into the output buffer, rd_cnt->0, go to DRAIN.
//    - Capture occurs exactly CORE_LATENCY edges after the last-sample edge.
//  - FSM DRAIN: m_valid=1; m_data_* = buffer[bin], m_index = bin, m_last = (rd_cnt==N-1).
//    - Accepted beat increments rd_cnt.
//    - Final beat accepted: m_valid drops, go to FILL, s_ready=1 next cycle, core_in retains old frame until overwritten.
//  - Throughput: single frame buffer, no overlap; a new frame is refused (s_ready=0) throughout WAIT/DRAIN.
//  - Arithmetic: no scaling or rounding; data passes bit-exact.
//  - Counters are log2(N_POINTS) wide and wrap by explicit reset, never by overflow.
//  - Reset mid-operation: immediate abort to reset values; the partial frame is discarded; no len_err.
// CONFIGURATION
//  - OUT_BITREV_EN defined:
//    - bin = bit-reverse(rd_cnt); m_index reports that bit-reversed bin.
//    - Lets the core skip its own output reorder.
//  - OUT_BITREV_EN undefined: bin = rd_cnt; natural order 0..N-1.
//  - Handshake, latency and m_last (on the Nth beat) are identical in both builds.
// TESTING  (N_POINTS=32, DATA_W=32, CORE_LATENCY=30; core stub = delay line, out_r[k]=in[k], out_i[k]=~in[k])
//  1. Samples 0x00000000..0x0000001F, s_last on 32nd, m_ready=1
//     -> m_valid exactly 30 edges after the last accept
//     -> 32 beats with m_data_r=k, m_data_i=~k, m_last on index 31, then s_ready=1.
//  2. Same frame, m_ready toggling 1,0,0,1...
//     -> outputs stable while stalled, no bin lost or duplicated
//     -> s_valid held high during DRAIN is never accepted.
//  3. s_last on 10th sample
//     -> len_err one cycle, no m_valid, next 32 samples form a good frame with correct output.
//  4. 32 samples, s_last never asserted -> len_err pulses on 32nd accept, frame still drained correctly.
//  5. rst=0 mid-DRAIN at beat 12 -> all outputs 0 immediately; after release a fresh frame processes normally.
//  6. OUT_BITREV_EN build, case 1 stimulus
//     -> m_index sequence 0,16,8,24,4,...,31
//     -> m_data_r equals m_index on every beat.

Source files
------------

// File: rtl/fft_stream_frame_adapter.sv
// fft_stream_frame_adapter
// Streaming wrapper around a parallel N-point FFT core. It collects N real samples into a
// frame and holds that frame on the core input bus. After the core's fixed latency it
// captures every complex output, then drains them one bin per beat on a valid/ready stream.
// Optional build macro: OUT_BITREV_EN drains the bins in bit-reversed order. m_index then
// reports the bit-reversed bin. When the macro is undefined, bins leave in natural order.
module fft_stream_frame_adapter #(
    parameter int unsigned N_POINTS     = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CORE_LATENCY = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_last,
    output logic [N_POINTS*DATA_W-1:0]   core_in,
    input  logic [N_POINTS*DATA_W-1:0]   core_out_r,
    input  logic [N_POINTS*DATA_W-1:0]   core_out_i,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_W-1:0]            m_data_r,
    output logic [DATA_W-1:0]            m_data_i,
    output logic [$clog2(N_POINTS)-1:0]  m_index,
    output logic                         m_last,
    output logic                         busy,
    output logic                         len_err
);

    localparam int unsigned IDX_W  = $clog2(N_POINTS);
    // The wait counter only has to hold CORE_LATENCY-1.
    localparam int unsigned WAIT_W = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_POINTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CORE_LATENCY - 1);

    typedef enum logic [1:0] {
        StFill,
        StWait,
        StDrain
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [IDX_W-1:0]             r_wr_cnt;
    logic [IDX_W-1:0]             w_wr_cnt_nxt;
    logic [WAIT_W-1:0]            r_wait_cnt;
    logic [WAIT_W-1:0]            w_wait_cnt_nxt;
    logic [IDX_W-1:0]             r_rd_cnt;
    logic [IDX_W-1:0]             w_rd_cnt_nxt;
    logic                         r_s_ready;
    logic                         r_len_err;
    logic                         w_len_err_nxt;
    logic [N_POINTS*DATA_W-1:0]   r_core_in;
    logic [N_POINTS*DATA_W-1:0]   r_buf_r;
    logic [N_POINTS*DATA_W-1:0]   r_buf_i;

    logic                         w_s_fire;
    logic                         w_m_valid;
    logic                         w_m_fire;
    logic                         w_wr_en;
    logic                         w_capture;
    logic [IDX_W-1:0]             w_bin;

    // s_ready is only ever high in FILL, so this fire also implies FILL.
    assign w_s_fire  = s_valid & r_s_ready;
    assign w_m_valid = (r_state == StDrain);
    assign w_m_fire  = w_m_valid & m_ready;

    // Map the drain counter to the bin that leaves on this beat.
    always_comb begin
        w_bin = r_rd_cnt;
`ifdef OUT_BITREV_EN
        for (int b = 0; b < int'(IDX_W); b++) begin
            w_bin[b] = r_rd_cnt[int'(IDX_W) - 1 - b];
        end
`endif
    end

    // Compute the next state, the counter updates and the write/capture strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_len_err_nxt  = 1'b0;
        w_wr_en        = 1'b0;
        w_capture      = 1'b0;
        unique case (r_state)
            StFill: begin
                if (w_s_fire) begin
                    if (r_wr_cnt == LAST_IDX) begin
                        // The frame is full. A missing s_last is flagged, but the frame still runs.
                        w_wr_en        = 1'b1;
                        w_wr_cnt_nxt   = '0;
                        w_wait_cnt_nxt = WAIT_INIT;
                        w_len_err_nxt  = ~s_last;
                        w_state_nxt    = StWait;
                    end else if (s_last) begin
                        // The frame is short. Drop this sample and restart the frame.
                        w_wr_cnt_nxt  = '0;
                        w_len_err_nxt = 1'b1;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    end
                end
            end
            StWait: begin
                if (r_wait_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_rd_cnt_nxt = '0;
                    w_state_nxt  = StDrain;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                end
            end
            StDrain: begin
                if (w_m_fire) begin
                    if (r_rd_cnt == LAST_IDX) begin
                        w_rd_cnt_nxt = '0;
                        w_state_nxt  = StFill;
                    end else begin
                        w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StFill;
            end
        endcase
    end

    // Register the state, counters and single-cycle flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StFill;
            r_wr_cnt   <= '0;
            r_wait_cnt <= '0;
            r_rd_cnt   <= '0;
            r_s_ready  <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            // s_ready is registered so that it stays low until the first edge after reset.
            r_s_ready  <= (w_state_nxt == StFill);
            r_len_err  <= w_len_err_nxt;
        end
    end

    // Write accepted samples into the frame. The frame holds its value outside FILL writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_in <= '0;
        end else if (w_wr_en) begin
            r_core_in[DATA_W*int'(r_wr_cnt) +: DATA_W] <= s_data;
        end
    end

    // Capture all core outputs at once when the latency count expires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_r <= '0;
            r_buf_i <= '0;
        end else if (w_capture) begin
            r_buf_r <= core_out_r;
            r_buf_i <= core_out_i;
        end
    end

    // Drive the output stream. The m_* outputs are forced to zero outside DRAIN.
    always_comb begin
        m_valid  = w_m_valid;
        m_data_r = '0;
        m_data_i = '0;
        m_index  = '0;
        m_last   = 1'b0;
        if (w_m_valid) begin
            m_data_r = r_buf_r[DATA_W*int'(w_bin) +: DATA_W];
            m_data_i = r_buf_i[DATA_W*int'(w_bin) +: DATA_W];
            m_index  = w_bin;
            m_last   = (r_rd_cnt == LAST_IDX);
        end
    end

    assign s_ready = r_s_ready;
    assign core_in = r_core_in;
    assign busy    = (r_state != StFill);
    assign len_err = r_len_err;

endmodule

// File: tb/tb_fft_stream_frame_adapter.sv
// Directed testbench for fft_stream_frame_adapter (N=32, DATA_W=32, CORE_LATENCY=30).
// The core stub is a delay line: out_r[k] = in[k] and out_i[k] = ~in[k].
// Build with OUT_BITREV_EN defined to expect bit-reversed drain order.
module tb_fft_stream_frame_adapter;

    localparam int N    = 32;
    localparam int W    = 32;
    localparam int LAT  = 30;
    localparam int STG  = LAT - 1;

    logic           clk;
    logic           rst;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;
    logic           s_last;
    logic [N*W-1:0] core_in;
    logic [N*W-1:0] core_out_r;
    logic [N*W-1:0] core_out_i;
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   m_data_r;
    logic [W-1:0]   m_data_i;
    logic [4:0]     m_index;
    logic           m_last;
    logic           busy;
    logic           len_err;

    int n_checks;
    int n_fail;

    fft_stream_frame_adapter #(
        .N_POINTS     (N),
        .DATA_W       (W),
        .CORE_LATENCY (LAT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .core_in    (core_in),
        .core_out_r (core_out_r),
        .core_out_i (core_out_i),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data_r   (m_data_r),
        .m_data_i   (m_data_i),
        .m_index    (m_index),
        .m_last     (m_last),
        .busy       (busy),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The core stub makes its outputs reflect a frame LAT edges after the adapter presents it.
    logic [N*W-1:0] pipe [STG];
    always_ff @(posedge clk) begin
        pipe[0] <= core_in;
        for (int i = 1; i < STG; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out_r = pipe[STG-1];
    assign core_out_i = ~pipe[STG-1];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_bin(input int j);
        logic [4:0] v;
        logic [4:0] r;
        v = 5'(j);
        r = v;
`ifdef OUT_BITREV_EN
        for (int b = 0; b < 5; b++) r[b] = v[4-b];
`endif
        return r;
    endfunction

    // Send one sample, wait for s_ready, and report len_err just after the accepting edge.
    task automatic send_sample(input logic [31:0] d, input logic last, output logic err);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check_eq("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
        err     = len_err;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Send samples base+k for k < n. s_last goes high at last_idx. len_err is expected at err_idx.
    task automatic send_frame(input logic [31:0] base, input int n, input int last_idx,
                              input int err_idx);
        logic e;
        for (int k = 0; k < n; k++) begin
            send_sample(base + 32'(k), (k == last_idx), e);
            check_eq($sformatf("len_err_s%0d", k), {63'd0, e}, {63'd0, (k == err_idx)});
        end
    endtask

    // Count edges from the last accept until m_valid rises, and check the latency.
    task automatic wait_out();
        int cnt;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                check_eq("busy_wait", {63'd0, busy}, 64'd1);
                check_eq("s_ready_wait", {63'd0, s_ready}, 64'd0);
            end
            if (m_valid) break;
        end
        check_eq("latency", 64'(cnt), 64'(LAT));
    endtask

    // Drain n_acc beats and check every cycle. A stalled beat must repeat the same values.
    task automatic drain_frame(input logic [31:0] base, input int n_acc, input bit stall,
                               input bit hold_s);
        int j;
        int p;
        logic [4:0] b;
        logic [31:0] v;
        j = 0;
        p = 0;
        if (hold_s) begin
            s_valid = 1'b1;
            s_data  = 32'hDEAD_BEEF;
            s_last  = 1'b0;
        end
        while (j < n_acc) begin
            m_ready = stall ? (p % 3 == 0) : 1'b1;
            b = exp_bin(j);
            v = base + 32'(b);
            check_eq($sformatf("m_valid_b%0d", j), {63'd0, m_valid}, 64'd1);
            check_eq($sformatf("m_index_b%0d", j), {59'd0, m_index}, {59'd0, b});
            check_eq($sformatf("m_data_r_b%0d", j), {32'd0, m_data_r}, {32'd0, v});
            check_eq($sformatf("m_data_i_b%0d", j), {32'd0, m_data_i}, {32'd0, ~v});
            check_eq($sformatf("m_last_b%0d", j), {63'd0, m_last}, {63'd0, (j == N-1)});
            if (hold_s) check_eq($sformatf("s_ready_drain_b%0d", j), {63'd0, s_ready}, 64'd0);
            @(posedge clk); #1;
            if (m_ready) j++;
            p++;
            if (p > 500) begin
                check_eq("drain_timeout", 0, 1);
                break;
            end
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        if (n_acc == N) begin
            check_eq("m_valid_drop", {63'd0, m_valid}, 64'd0);
            check_eq("busy_done", {63'd0, busy}, 64'd0);
            check_eq("s_ready_done", {63'd0, s_ready}, 64'd1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check_eq("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_len_err", {63'd0, len_err}, 64'd0);
        check_eq("rst_core_in", {63'd0, (core_in == '0)}, 64'd1);
        check_eq("rst_m_data", {m_data_r, m_data_i}, 64'd0);
        rst = 1'b1;
        #1;
        check_eq("s_ready_before_edge", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #1;
        check_eq("s_ready_after_edge", {63'd0, s_ready}, 64'd1);

        // Case 1 (and the bit-reversed case when OUT_BITREV_EN is defined): a good frame.
        send_frame(32'h0, N, N-1, -1);
        check_eq("core_in_slot5", {32'd0, core_in[5*W +: W]}, 64'd5);
        check_eq("core_in_slot31", {32'd0, core_in[31*W +: W]}, 64'h1F);
        wait_out();
        drain_frame(32'h0, N, 1'b0, 1'b0);

        // Case 2: stalled drain while the source holds s_valid high.
        send_frame(32'h100, N, N-1, -1);
        wait_out();
        drain_frame(32'h100, N, 1'b1, 1'b1);

        // Case 3: early s_last on sample 10, then a good frame.
        send_frame(32'h200, 10, 9, 9);
        @(posedge clk); #1;
        check_eq("len_err_one_cycle", {63'd0, len_err}, 64'd0);
        check_eq("no_m_valid_short", {63'd0, m_valid}, 64'd0);
        check_eq("s_ready_short", {63'd0, s_ready}, 64'd1);
        send_frame(32'h300, N, N-1, -1);
        wait_out();
        drain_frame(32'h300, N, 1'b0, 1'b0);

        // Case 4: no s_last anywhere. len_err pulses on the 32nd sample, and the frame still drains.
        send_frame(32'h400, N, -1, N-1);
        wait_out();
        drain_frame(32'h400, N, 1'b0, 1'b0);

        // Case 5: reset in the middle of the drain at beat 12, then a fresh frame.
        send_frame(32'h500, N, N-1, -1);
        wait_out();
        drain_frame(32'h500, 12, 1'b0, 1'b0);
        m_ready = 1'b1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
        check_eq("mid_rst_m_data", {m_data_r, m_data_i}, 64'd0);
        check_eq("mid_rst_m_index", {58'd0, m_index, m_last}, 64'd0);
        check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
        check_eq("mid_rst_len_err", {63'd0, len_err}, 64'd0);
        check_eq("mid_rst_core_in", {63'd0, (core_in == '0)}, 64'd1);
        m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
        send_frame(32'h600, N, N-1, -1);
        wait_out();
        drain_frame(32'h600, N, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
